// File: rtl/i2c_rtc_pkg.sv
// Shared I2C definitions: FSM state encoding, default target address,
// and the bus-level ACK/NACK bit values.
package i2c_rtc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_IGNORE    = 4'd9
  } i2c_state_e;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h68;
  localparam logic       I2C_ACK            = 1'b0;
  localparam logic       I2C_NACK           = 1'b1;

endpackage

// File: rtl/i2c_rtc_target_sync.sv
// Bus line conditioning: synchronizes SCL/SDA into sys_clk and flags
// SCL edges plus START/STOP conditions from the synchronized lines.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // One extra flop beyond the synchronizer holds the previous sample for edge detection.
  logic [SYNC_STAGES:0] scl_sh_q, scl_sh_d;
  logic [SYNC_STAGES:0] sda_sh_q, sda_sh_d;
  logic scl_s, scl_p, sda_p;

  // Shift the raw pad values into the synchronizer chains.
  always_comb begin
    scl_sh_d = {scl_sh_q[SYNC_STAGES-1:0], scl_in};
    sda_sh_d = {sda_sh_q[SYNC_STAGES-1:0], sda_in};
  end

  // Chains reset to the idle-bus level so reset release looks like a quiet bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sh_q <= '1;
      sda_sh_q <= '1;
    end else begin
      scl_sh_q <= scl_sh_d;
      sda_sh_q <= sda_sh_d;
    end
  end

  assign scl_s     = scl_sh_q[SYNC_STAGES-1];
  assign scl_p     = scl_sh_q[SYNC_STAGES];
  assign sda_s     = sda_sh_q[SYNC_STAGES-1];
  assign sda_p     = sda_sh_q[SYNC_STAGES];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

endmodule

// File: rtl/i2c_rtc_target.sv
// I2C target exposing a small byte register file with an auto-incrementing
// pointer; a local update port lets the timekeeping core refresh registers.
//
// state        | meaning
// IDLE         | bus free or not yet addressed
// ADDR         | shifting in address + R/W
// ADDR_ACK     | driving ACK for our address
// PTR          | shifting in register pointer
// PTR_ACK      | driving ACK for pointer byte
// WDATA        | shifting in a write data byte
// WDATA_ACK    | byte committed, driving ACK
// RDATA        | shifting out reg[ptr]
// RDATA_ACK    | SDA released, sampling initiator ACK/NACK
// IGNORE       | not for us or read ended; wait for START/STOP
module i2c_rtc_target import i2c_rtc_pkg::*; #(
  parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
  parameter int         NUM_REGS    = 8,
  parameter int         SYNC_STAGES = 2,
  localparam int        AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          i2c_scl,
  input  logic          i2c_sda_in,
  output logic          i2c_sda_oe,
  input  logic          upd_valid,
  input  logic [AW-1:0] upd_addr,
  input  logic [7:0]    upd_data,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .scl_in    (i2c_scl),
    .sda_in    (i2c_sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [AW-1:0] ptr_q, ptr_d, ptr_inc;
  logic          sda_oe_q, sda_oe_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    regs_q [NUM_REGS];
  logic [7:0]    regs_d [NUM_REGS];
  logic          in_byte, byte_done, commit;

  assign ptr_inc = ptr_q + 1'b1;

  // Protocol FSM: bits shift on SCL rise, decisions and SDA changes on SCL fall.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    commit    = 1'b0;

    in_byte   = (state_q == ST_ADDR) || (state_q == ST_PTR) ||
                (state_q == ST_WDATA) || (state_q == ST_RDATA);
    byte_done = in_byte && scl_fall && (bit_cnt_q == 4'd8);

    if (in_byte && scl_rise && (bit_cnt_q != 4'd8)) begin
      sh_d      = {sh_q[6:0], sda_s};
      bit_cnt_d = bit_cnt_q + 4'd1;
    end

    case (state_q)
      ST_ADDR: if (byte_done) begin
        bit_cnt_d = '0;
        if (sh_q[7:1] == SLAVE_ADDR) begin
          state_d  = ST_ADDR_ACK;
          sda_oe_d = 1'b1;
        end else begin
          state_d  = ST_IGNORE;
        end
      end
      ST_ADDR_ACK: if (scl_fall) begin
        if (sh_q[0]) begin
          state_d  = ST_RDATA;
          sh_d     = regs_q[ptr_q];
          sda_oe_d = ~regs_q[ptr_q][7];
        end else begin
          state_d  = ST_PTR;
          sda_oe_d = 1'b0;
        end
      end
      ST_PTR: if (byte_done) begin
        bit_cnt_d = '0;
        ptr_d     = sh_q[AW-1:0];
        state_d   = ST_PTR_ACK;
        sda_oe_d  = 1'b1;
      end
      ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
        state_d  = ST_WDATA;
        sda_oe_d = 1'b0;
      end
      ST_WDATA: if (byte_done) begin
        bit_cnt_d = '0;
        commit    = 1'b1;
        ptr_d     = ptr_inc;
        state_d   = ST_WDATA_ACK;
        sda_oe_d  = 1'b1;
      end
      ST_RDATA: begin
        if (byte_done) begin
          bit_cnt_d = '0;
          state_d   = ST_RDATA_ACK;
          sda_oe_d  = 1'b0;
        end else if (scl_fall) begin
          sda_oe_d  = ~sh_q[7];
        end
      end
      ST_RDATA_ACK: begin
        if (scl_rise) sh_d[0] = sda_s;
        if (scl_fall) begin
          if (sh_q[0] == I2C_ACK) begin
            ptr_d    = ptr_inc;
            sh_d     = regs_q[ptr_inc];
            state_d  = ST_RDATA;
            sda_oe_d = ~regs_q[ptr_inc][7];
          end else begin
            state_d  = ST_IGNORE;
          end
        end
      end
      default: ;
    endcase

    // START/STOP abandon whatever byte is in flight.
    if (start_det || stop_det) begin
      state_d   = start_det ? ST_ADDR : ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      ptr_d     = ptr_q;
      commit    = 1'b0;
    end
  end

  // Register file next value; the I2C commit is applied last so it wins a same-index clash.
  always_comb begin
    regs_d = regs_q;
    if (upd_valid) regs_d[upd_addr] = upd_data;
    if (commit) regs_d[ptr_q] = sh_q;
    wr_strobe_d = commit;
    wr_addr_d   = commit ? ptr_q : wr_addr_q;
    wr_data_d   = commit ? sh_q  : wr_data_q;
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end

  assign i2c_sda_oe = sda_oe_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_i2c_rtc_target.sv
// Self-checking bench for i2c_rtc_target: bit-banged I2C initiator plus a
// register/pointer reference model kept as plain arrays.
module tb_i2c_rtc_target;

  localparam int         QTR = 10;
  localparam logic [6:0] TGT = 7'h68;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       m_scl     = 1'b1;
  logic       m_sda     = 1'b1;
  logic       sda_bus;
  logic       upd_valid = 1'b0;
  logic [2:0] upd_addr  = '0;
  logic [7:0] upd_data  = '0;
  logic       i2c_sda_oe, wr_strobe;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  m_regs [8];
  logic [2:0]  m_ptr;
  logic [10:0] strobe_q [$];

  always #10 sys_clk = ~sys_clk;
  assign sda_bus = m_sda & ~i2c_sda_oe;

  i2c_rtc_target dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .i2c_scl    (m_scl),
    .i2c_sda_in (sda_bus),
    .i2c_sda_oe (i2c_sda_oe),
    .upd_valid  (upd_valid),
    .upd_addr   (upd_addr),
    .upd_data   (upd_data),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  always @(negedge sys_clk)
    if (sys_rst_n && wr_strobe) strobe_q.push_back({wr_addr, wr_data});

  initial begin
    #1_900_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- bus primitives ----------------
  task automatic wait_q();
    repeat (QTR) @(negedge sys_clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; wait_q();
    m_scl = 1'b1; wait_q(); wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    b = sda_bus; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic nack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(nack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic upd_write(input logic [2:0] a, input logic [7:0] d);
    upd_addr = a; upd_data = d; upd_valid = 1'b1;
    @(negedge sys_clk);
    upd_valid = 1'b0;
  endtask

  task automatic preload_random();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = 8'($urandom());
      upd_write(3'(i), v);
      m_regs[i] = v;
    end
  endtask

  // Full write transaction; the pointer byte carries random upper bits.
  task automatic do_write(input logic [2:0] p, input logic [7:0] data[$], output int nacks);
    logic       n;
    logic [7:0] pb;
    nacks = 0;
    pb = 8'($urandom());
    pb[2:0] = p;
    i2c_start();
    write_byte({TGT, 1'b0}, n); nacks += int'(n);
    write_byte(pb, n);          nacks += int'(n);
    foreach (data[i]) begin
      write_byte(data[i], n);   nacks += int'(n);
    end
    i2c_stop();
  endtask

  task automatic do_read(input int cnt, output logic addr_nack, output logic [7:0] got [8]);
    i2c_start();
    write_byte({TGT, 1'b1}, addr_nack);
    for (int i = 0; i < cnt; i++) read_byte(i == cnt - 1, got[i]);
    i2c_stop();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic an;
    logic [7:0] got [8];
    sys_rst_n = 1'b0;
    repeat (4) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_ptr = 3'd0;
    n_checks++; if (i2c_sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", i2c_sda_oe); end
    n_checks++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b expected 0", wr_strobe); end
    n_checks++; if ({wr_addr, wr_data} !== 11'h0) begin n_fail++; $display("FAIL reset_wr: got %h/%h expected 0/00", wr_addr, wr_data); end
    do_read(8, an, got);
    n_checks++; if (an !== 1'b0) begin n_fail++; $display("FAIL reset_read_ack: got %b expected 0", an); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (got[i] !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 00", i, got[i]); end
    end
    m_ptr = 3'd7;
  endtask

  task automatic test_write_basic();
    logic [7:0] wq [$];
    logic [7:0] got [8];
    logic an;
    int nk;
    preload_random();
    strobe_q.delete();
    wq = {8'h15, 8'h59};
    do_write(3'd2, wq, nk);
    m_regs[2] = 8'h15; m_regs[3] = 8'h59; m_ptr = 3'd4;
    n_checks++; if (nk !== 0) begin n_fail++; $display("FAIL wr_basic_acks: got %0d nacks expected 0", nk); end
    n_checks++; if (strobe_q.size() !== 2) begin n_fail++; $display("FAIL wr_basic_nstrobe: got %0d expected 2", strobe_q.size()); end
    else begin
      n_checks++; if (strobe_q[0] !== {3'd2, 8'h15}) begin n_fail++; $display("FAIL wr_basic_strobe0: got %h expected %h", strobe_q[0], {3'd2, 8'h15}); end
      n_checks++; if (strobe_q[1] !== {3'd3, 8'h59}) begin n_fail++; $display("FAIL wr_basic_strobe1: got %h expected %h", strobe_q[1], {3'd3, 8'h59}); end
    end
    wq.delete();
    do_write(3'd2, wq, nk);
    do_read(2, an, got);
    m_ptr = 3'd3;
    n_checks++; if (got[0] !== 8'h15 || got[1] !== 8'h59) begin n_fail++; $display("FAIL wr_basic_readback: got %h %h expected 15 59", got[0], got[1]); end
  endtask

  task automatic test_read_burst();
    logic n;
    int nk = 0;
    logic [7:0] d [3];
    preload_random();
    i2c_start();
    write_byte({TGT, 1'b0}, n); nk += int'(n);
    write_byte(8'h00, n);       nk += int'(n);
    i2c_start();
    write_byte({TGT, 1'b1}, n); nk += int'(n);
    read_byte(1'b0, d[0]);
    read_byte(1'b0, d[1]);
    read_byte(1'b1, d[2]);
    wait_q();
    n_checks++; if (i2c_sda_oe !== 1'b0) begin n_fail++; $display("FAIL burst_release: got oe=%b expected 0", i2c_sda_oe); end
    i2c_stop();
    n_checks++; if (nk !== 0) begin n_fail++; $display("FAIL burst_acks: got %0d nacks expected 0", nk); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (d[i] !== m_regs[i]) begin n_fail++; $display("FAIL burst_byte%0d: got %h expected %h", i, d[i], m_regs[i]); end
    end
    m_ptr = 3'd2;
  endtask

  task automatic test_wrong_addr();
    logic n0, n1, n2, an;
    logic [7:0] got [8];
    strobe_q.delete();
    i2c_start();
    write_byte({7'h50, 1'b0}, n0);
    write_byte(8'h03, n1);
    write_byte(8'hEE, n2);
    i2c_stop();
    n_checks++; if (n0 !== 1'b1) begin n_fail++; $display("FAIL wrong_addr_ack: got %b expected 1", n0); end
    n_checks++; if ({n1, n2} !== 2'b11) begin n_fail++; $display("FAIL wrong_addr_data_ack: got %b expected 11", {n1, n2}); end
    n_checks++; if (strobe_q.size() !== 0) begin n_fail++; $display("FAIL wrong_addr_strobe: got %0d expected 0", strobe_q.size()); end
    do_read(2, an, got);
    n_checks++; if (got[0] !== m_regs[m_ptr] || got[1] !== m_regs[m_ptr + 3'd1]) begin
      n_fail++; $display("FAIL wrong_addr_regs: got %h %h expected %h %h", got[0], got[1], m_regs[m_ptr], m_regs[m_ptr + 3'd1]);
    end
    m_ptr = m_ptr + 3'd1;
  endtask

  task automatic test_wrap();
    logic [7:0] wq [$];
    logic [7:0] got [8];
    logic an;
    int nk;
    strobe_q.delete();
    wq = {8'hAA, 8'hBB};
    do_write(3'd7, wq, nk);
    m_regs[7] = 8'hAA; m_regs[0] = 8'hBB; m_ptr = 3'd1;
    n_checks++; if (nk !== 0) begin n_fail++; $display("FAIL wrap_acks: got %0d expected 0", nk); end
    n_checks++; if (strobe_q.size() !== 2 || strobe_q[0] !== {3'd7, 8'hAA} || strobe_q[1] !== {3'd0, 8'hBB}) begin
      n_fail++; $display("FAIL wrap_strobes: got %0d entries expected 7:aa then 0:bb", strobe_q.size());
    end
    wq.delete();
    do_write(3'd7, wq, nk);
    do_read(2, an, got);
    m_ptr = 3'd0;
    n_checks++; if (got[0] !== 8'hAA || got[1] !== 8'hBB) begin n_fail++; $display("FAIL wrap_readback: got %h %h expected aa bb", got[0], got[1]); end
  endtask

  task automatic test_abort();
    logic [7:0] wq [$];
    logic [7:0] got [8];
    logic [2:0] p;
    logic n, an;
    int nk;
    p = 3'($urandom_range(0, 7));
    wq.delete();
    do_write(p, wq, nk);
    m_ptr = p;
    strobe_q.delete();
    i2c_start();
    write_byte({TGT, 1'b0}, n);
    write_byte({5'b0, p}, n);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom()));
    i2c_stop();
    n_checks++; if (strobe_q.size() !== 0) begin n_fail++; $display("FAIL abort_data_strobe: got %0d expected 0", strobe_q.size()); end
    do_read(1, an, got);
    n_checks++; if (got[0] !== m_regs[p]) begin n_fail++; $display("FAIL abort_data_read: got %h expected %h", got[0], m_regs[p]); end
    i2c_start();
    write_byte({TGT, 1'b0}, n);
    for (int i = 0; i < 4; i++) send_bit(~p[0]);
    i2c_stop();
    do_read(1, an, got);
    n_checks++; if (got[0] !== m_regs[p]) begin n_fail++; $display("FAIL abort_ptr_read: got %h expected %h", got[0], m_regs[p]); end
  endtask

  task automatic test_upd_during_read();
    logic [7:0] wq [$];
    logic [7:0] got [8];
    logic [7:0] exp_v, new_v, d;
    logic [2:0] p;
    logic n, an;
    int nk;
    preload_random();
    p = 3'($urandom_range(0, 7));
    wq.delete();
    do_write(p, wq, nk);
    exp_v = m_regs[p];
    new_v = ~exp_v;
    i2c_start();
    write_byte({TGT, 1'b1}, n);
    fork
      read_byte(1'b1, d);
      begin
        repeat (12 * QTR) @(negedge sys_clk);
        upd_write(p, new_v);
      end
    join
    i2c_stop();
    m_regs[p] = new_v;
    m_ptr = p;
    n_checks++; if (d !== exp_v) begin n_fail++; $display("FAIL upd_read_stable: got %h expected %h", d, exp_v); end
    do_read(1, an, got);
    n_checks++; if (got[0] !== new_v) begin n_fail++; $display("FAIL upd_read_after: got %h expected %h", got[0], new_v); end
  endtask

  task automatic test_collision();
    logic [7:0] wq [$];
    logic [7:0] got [8];
    logic [2:0] p, p1, q;
    logic [7:0] di0, di1, dx, dy;
    logic n, an;
    int nk = 0;
    bit seen;
    p = 3'($urandom_range(0, 7)); p1 = p + 3'd1; q = p + 3'd3;
    di0 = 8'($urandom()); di1 = 8'($urandom());
    dx = ~di0; dy = 8'($urandom());
    i2c_start();
    write_byte({TGT, 1'b0}, n); nk += int'(n);
    write_byte({5'b0, p}, n);   nk += int'(n);
    for (int k = 0; k < 2; k++) begin
      seen = 1'b0;
      fork
        begin write_byte(k == 0 ? di0 : di1, n); nk += int'(n); end
        begin
          upd_addr = (k == 0) ? p : q; upd_data = (k == 0) ? dx : dy; upd_valid = 1'b1;
          for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge sys_clk);
            if (wr_strobe) seen = 1'b1;
          end
          upd_valid = 1'b0;
        end
      join
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL collide_strobe%0d: got no strobe expected one within bound", k); end
    end
    i2c_stop();
    m_regs[p] = di0; m_regs[q] = dy; m_regs[p1] = di1; m_ptr = p + 3'd2;
    n_checks++; if (nk !== 0) begin n_fail++; $display("FAIL collide_acks: got %0d expected 0", nk); end
    wq.delete();
    do_write(p, wq, nk);
    do_read(2, an, got);
    n_checks++; if (got[0] !== m_regs[p] || got[1] !== m_regs[p1]) begin
      n_fail++; $display("FAIL collide_i2c_wins: got %h %h expected %h %h", got[0], got[1], m_regs[p], m_regs[p1]);
    end
    do_write(q, wq, nk);
    do_read(1, an, got);
    m_ptr = q;
    n_checks++; if (got[0] !== dy) begin n_fail++; $display("FAIL collide_other_idx: got %h expected %h", got[0], dy); end
  endtask

  task automatic test_random();
    logic [7:0] wq [$];
    logic [7:0] got [8];
    logic [2:0] p, a;
    logic an;
    int len, nk;
    for (int it = 0; it < 3; it++) begin
      p = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 3);
      wq.delete();
      for (int i = 0; i < len; i++) wq.push_back(8'($urandom()));
      strobe_q.delete();
      do_write(p, wq, nk);
      n_checks++; if (nk !== 0) begin n_fail++; $display("FAIL rand%0d_acks: got %0d expected 0", it, nk); end
      n_checks++; if (strobe_q.size() !== len) begin n_fail++; $display("FAIL rand%0d_nstrobe: got %0d expected %0d", it, strobe_q.size(), len); end
      a = p;
      for (int i = 0; i < len; i++) begin
        m_regs[a] = wq[i];
        if (i < strobe_q.size()) begin
          n_checks++; if (strobe_q[i] !== {a, wq[i]}) begin n_fail++; $display("FAIL rand%0d_strobe%0d: got %h expected %h", it, i, strobe_q[i], {a, wq[i]}); end
        end
        a = a + 3'd1;
      end
      wq.delete();
      do_write(p, wq, nk);
      do_read(len, an, got);
      a = p;
      for (int i = 0; i < len; i++) begin
        n_checks++; if (got[i] !== m_regs[a]) begin n_fail++; $display("FAIL rand%0d_read%0d: got %h expected %h", it, i, got[i], m_regs[a]); end
        a = a + 3'd1;
      end
      m_ptr = p + 3'(len - 1);
    end
  endtask

  task automatic test_ptr_persist();
    logic [7:0] got [8];
    logic an;
    do_read(1, an, got);
    n_checks++; if (got[0] !== m_regs[m_ptr]) begin n_fail++; $display("FAIL ptr_persist: got %h expected %h", got[0], m_regs[m_ptr]); end
  endtask

  task automatic test_reset_during_read();
    logic [7:0] wq [$];
    logic [7:0] got [8];
    logic [2:0] p;
    logic b7, b6, n, an;
    int nk;
    p = 3'($urandom_range(0, 7));
    upd_write(p, 8'h00);
    wq.delete();
    do_write(p, wq, nk);
    i2c_start();
    write_byte({TGT, 1'b1}, n);
    recv_bit(b7);
    recv_bit(b6);
    n_checks++; if ({b7, b6} !== 2'b00) begin n_fail++; $display("FAIL rst_read_bits: got %b expected 00", {b7, b6}); end
    n_checks++; if (i2c_sda_oe !== 1'b1) begin n_fail++; $display("FAIL rst_read_driving: got oe=%b expected 1", i2c_sda_oe); end
    #3;
    sys_rst_n = 1'b0;
    #1;
    n_checks++; if (i2c_sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_read_oe: got %b expected 0", i2c_sda_oe); end
    m_scl = 1'b1; m_sda = 1'b1;
    repeat (4) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    do_read(8, an, got);
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (got[i] !== m_regs[i]) begin n_fail++; $display("FAIL rst_read_reg%0d: got %h expected %h", i, got[i], m_regs[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_burst();
    test_wrong_addr();
    test_wrap();
    test_abort();
    test_upd_during_read();
    test_collision();
    test_random();
    test_ptr_persist();
    test_reset_during_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
